moore_seq_detector_param: RTL and testbench

//   Parametrised Moore-type serial pattern detector, successor to the fixed "110" detector.
//   Bit pattern of length PAT_LEN is runtime-programmable, with selectable overlapping or
//   non-overlapping matching, a sample-enable input, a saturating match counter and a

---
 rtl/moore_seq_detector_param.sv | 144 ++++++++++++++
 tb/tb_moore_seq_detector_param.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/moore_seq_detector_param.sv
// moore_seq_detector_param
//   Moore-type serial pattern detector with a runtime-programmable PAT_LEN-bit
//   pattern. It supports overlapping or restart-after-match operation, a sample
//   enable, a saturating match counter and a progress output.
//
//   Ports
//     clk        rising-edge clock for all logic
//     rst        synchronous reset, active-high
//     en         data_in is accepted on an edge only while en=1
//     data_in    serial data bit
//     cfg_load   latch pattern/overlap and restart matching; data_in is ignored
//     pattern    new pattern; bit [PAT_LEN-1] is the first bit received
//     overlap    1 = overlapping matches, 0 = restart after each match
//     cnt_clr    clear match_cnt; it reads 1 if the same edge enters DETECTED
//     detected   1 while the FSM is in DETECTED
//     progress   matched prefix length; PAT_LEN in DETECTED. It is the state
//                encoding itself, so it doubles as the FSM state debug view.
//     match_cnt  number of DETECTED entries, saturating
//
//   Handshake: a bit transfers on a rising edge when en=1 and neither rst nor
//   cfg_load is high. There is no back-pressure; the detector always accepts.
module moore_seq_detector_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PAT_RST = 4'b1101,
  parameter int                 CNT_W   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           data_in,
  input  logic                           cfg_load,
  input  logic [PAT_LEN-1:0]             pattern,
  input  logic                           overlap,
  input  logic                           cnt_clr,
  output logic                           detected,
  output logic [$clog2(PAT_LEN+1)-1:0]   progress,
  output logic [CNT_W-1:0]               match_cnt
);

  localparam int SW = $clog2(PAT_LEN + 1);

  // MATCH_k is encoded as the value k, so only the two end points are named.
  typedef enum logic [SW-1:0] {
    MATCH_0  = '0,
    DETECTED = SW'(PAT_LEN)
  } state_e;

  state_e             state;
  state_e             state_d;
  logic [PAT_LEN-1:0] pat_q;
  logic               ovl_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               state_legal;
  logic [SW-1:0]      state_bits;
  logic [SW-1:0]      cur_len;
  logic [SW-1:0]      nxt_len;
  logic               entry;

  // Next matched length after appending bit b to the first p pattern bits.
  // The fallback is the longest suffix of that sequence that is also a prefix
  // of the pattern, so only the pattern and the current length are needed.
  function automatic logic [SW-1:0] next_len(
    input logic [SW-1:0]      p,
    input logic               b,
    input logic [PAT_LEN-1:0] pat
  );
    logic [PAT_LEN:0] s;
    int               pi;
    int               best;
    int               idx;
    logic             ok;
    pi = int'(p);
    for (int i = 0; i < PAT_LEN; i++) begin
      s[i] = (i < pi) ? pat[PAT_LEN-1-i] : ((i == pi) ? b : 1'b0);
    end
    s[PAT_LEN] = (pi == PAT_LEN) ? b : 1'b0;
    best = 0;
    for (int n = 1; n <= PAT_LEN; n++) begin
      if (n <= pi + 1) begin
        ok = 1'b1;
        for (int j = 0; j < PAT_LEN; j++) begin
          if (j < n) begin
            idx = pi + 1 - n + j;
            if (s[idx[SW-1:0]] != pat[PAT_LEN-1-j]) ok = 1'b0;
          end
        end
        if (ok) best = n;
      end
    end
    return SW'(best);
  endfunction

  assign state_bits  = state;
  assign state_legal = (state <= DETECTED);

  // A held DETECTED continues from PAT_LEN when overlapping and from zero when not.
  always_comb begin
    cur_len = state_bits;
    if (state == DETECTED) cur_len = ovl_q ? SW'(PAT_LEN) : '0;
  end

  assign nxt_len = next_len(cur_len, data_in, pat_q);

  always_comb begin
    state_d = state;
    cnt_d   = cnt_q;
    entry   = 1'b0;
    if (cfg_load) begin
      state_d = MATCH_0;
    end else if (!state_legal) begin
      state_d = MATCH_0;
    end else if (en) begin
      state_d = state_e'(nxt_len);
      entry   = (nxt_len == SW'(PAT_LEN));
    end
    if (cnt_clr) begin
      cnt_d = entry ? CNT_W'(1) : '0;
    end else if (entry && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MATCH_0;
      pat_q <= PAT_RST;
      ovl_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      state <= state_d;
      cnt_q <= cnt_d;
      if (cfg_load) begin
        pat_q <= pattern;
        ovl_q <= overlap;
      end
    end
  end

  assign detected  = (state == DETECTED);
  assign progress  = state_legal ? state_bits : '0;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_moore_seq_detector_param.sv
module tb_moore_seq_detector_param;

  // ---------------- clock / reset / signals ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       data_in = 1'b0;
  logic       cfg_load = 1'b0;
  logic [3:0] pattern = 4'b0000;
  logic       overlap = 1'b0;
  logic       cnt_clr = 1'b0;

  logic       detected, detected2;
  logic [2:0] progress, progress2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;

  always #5 clk = ~clk;

  moore_seq_detector_param #(.PAT_LEN(4), .PAT_RST(4'b1101), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .cfg_load(cfg_load),
    .pattern(pattern), .overlap(overlap), .cnt_clr(cnt_clr),
    .detected(detected), .progress(progress), .match_cnt(match_cnt)
  );

  // Same stimulus, narrow counter for saturation behaviour.
  moore_seq_detector_param #(.PAT_LEN(4), .PAT_RST(4'b1101), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .cfg_load(cfg_load),
    .pattern(pattern), .overlap(overlap), .cnt_clr(cnt_clr),
    .detected(detected2), .progress(progress2), .match_cnt(match_cnt2)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;

  // History of accepted bits since the last restart (last 4 kept).
  logic       hist_q[$];
  logic [3:0] m_pat = 4'b1101;
  logic       m_ovl = 1'b1;
  int         m_len = 0;
  int         m_cnt = 0;
  int         m_cnt2 = 0;
  logic       chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Longest suffix of the history that equals a prefix of the pattern.
  function automatic int longest_match();
    int sz;
    logic ok;
    sz = hist_q.size();
    for (int n = sz; n >= 1; n--) begin
      ok = 1'b1;
      for (int j = 0; j < n; j++)
        if (hist_q[sz - n + j] != m_pat[3 - j]) ok = 1'b0;
      if (ok) return n;
    end
    return 0;
  endfunction

  task automatic model_update(input logic r, input logic c, input logic e, input logic d,
                              input logic clr, input logic [3:0] p, input logic o);
    logic entry;
    entry = 1'b0;
    if (r) begin
      m_pat = 4'b1101; m_ovl = 1'b1; hist_q.delete(); m_len = 0; m_cnt = 0; m_cnt2 = 0;
      return;
    end
    if (c) begin
      m_pat = p; m_ovl = o; hist_q.delete(); m_len = 0;
    end else if (e) begin
      if (m_len == 4 && !m_ovl) hist_q.delete();
      hist_q.push_back(d);
      if (hist_q.size() > 4) void'(hist_q.pop_front());
      m_len = longest_match();
      entry = (m_len == 4);
    end
    if (clr) begin
      m_cnt  = entry ? 1 : 0;
      m_cnt2 = entry ? 1 : 0;
    end else if (entry) begin
      m_cnt  = (m_cnt  < 255) ? m_cnt + 1  : 255;
      m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
    end
  endtask

  // Compare process: outputs are Moore, checked every cycle away from the edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_detected",  detected,   (m_len == 4));
      chk("cyc_progress",  progress,   m_len);
      chk("cyc_match_cnt", match_cnt,  m_cnt);
      chk("cyc_detected2", detected2,  (m_len == 4));
      chk("cyc_progress2", progress2,  m_len);
      chk("cyc_match_cnt2", match_cnt2, m_cnt2);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic r, input logic c, input logic e, input logic d,
                      input logic clr, input logic [3:0] p, input logic o);
    @(negedge clk);
    rst = r; cfg_load = c; en = e; data_in = d; cnt_clr = clr; pattern = p; overlap = o;
    @(posedge clk);
    model_update(r, c, e, d, clr, p, o);
    if (r) chk_on = 1'b1;
    #2;
  endtask

  task automatic send(input logic d, input logic clr = 1'b0);
    step(1'b0, 1'b0, 1'b1, d, clr, 4'b0000, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
  endtask

  // data_in/en held high during the load to show they are ignored.
  task automatic load(input logic [3:0] p, input logic o, input logic clr);
    step(1'b0, 1'b1, 1'b1, 1'b1, clr, p, o);
  endtask

  task automatic do_rst();
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic send_vec(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send(v[i]);
  endtask

  // ---------------- directed sequence ----------------
  int hi_cycles;
  logic [31:0] mix_bits = 32'b1101_1011_0110_1101_0011_1101_1111_0101;
  logic [31:0] mix_en   = 32'b1110_1111_0111_1101_1111_1011_1110_1111;

  initial begin
    do_rst();
    do_rst();
    chk("rst_detected", detected, 0);
    chk("rst_progress", progress, 0);
    chk("rst_match_cnt", match_cnt, 0);

    // 1: 1101 overlapping, stream 1101101
    send_vec(16'b1101, 4);
    chk("t1_det_after_bit4", detected, 1);
    send(1'b1);
    chk("t1_progress_bit5", progress, 2);
    send(1'b0);
    send(1'b1);
    chk("t1_det_after_bit7", detected, 1);
    chk("t1_match_cnt", match_cnt, 2);

    // 2: same stream, restart after match; restart leaves 1,0,1 -> length 1
    load(4'b1101, 1'b0, 1'b1);
    chk("t2_cnt_cleared_on_load", match_cnt, 0);
    send_vec(16'b1101, 4);
    chk("t2_det_after_bit4", detected, 1);
    send_vec(16'b101, 3);
    chk("t2_progress_bit7", progress, 1);
    chk("t2_match_cnt", match_cnt, 1);

    // cnt_clr alone
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
    chk("cnt_clr_alone", match_cnt, 0);

    // 3: 1111 overlapping, seven ones
    load(4'b1111, 1'b1, 1'b0);
    hi_cycles = 0;
    for (int i = 0; i < 7; i++) begin
      send(1'b1);
      if (detected === 1'b1) hi_cycles++;
    end
    chk("t3_det_cycles_ovl", hi_cycles, 4);
    chk("t3_match_cnt_ovl", match_cnt, 4);
    load(4'b1111, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) send(1'b1);
    chk("t3_match_cnt_novl", match_cnt, 1);
    chk("t3_progress_novl", progress, 3);

    // 4: en gaps
    load(4'b1101, 1'b1, 1'b0);
    send(1'b1);
    send(1'b1);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("t4_progress_gap", progress, 2);
    end
    send(1'b0);
    send(1'b1);
    chk("t4_det_final_bit", detected, 1);
    idle();
    idle();
    chk("t4_det_held", detected, 1);
    send(1'b0);
    chk("t4_det_dropped", detected, 0);

    // 5: saturation on the 2-bit counter, then cnt_clr on an entry
    load(4'b1111, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) send(1'b1);
    chk("t5_cnt2_saturated", match_cnt2, 3);
    chk("t5_cnt_wide", match_cnt, 5);
    send(1'b1, 1'b1);
    chk("t5_cnt2_clr_entry", match_cnt2, 1);
    chk("t5_cnt_clr_entry", match_cnt, 1);

    // 6: reconfigure mid-match, then reset mid-match
    load(4'b1101, 1'b1, 1'b0);
    send_vec(16'b110, 3);
    chk("t6_progress_3", progress, 3);
    load(4'b0110, 1'b1, 1'b0);
    chk("t6_progress_after_load", progress, 0);
    send_vec(16'b0110, 4);
    chk("t6_det_0110", detected, 1);
    load(4'b1101, 1'b1, 1'b0);
    send_vec(16'b110, 3);
    do_rst();
    chk("t6_rst_detected", detected, 0);
    chk("t6_rst_progress", progress, 0);
    chk("t6_rst_match_cnt", match_cnt, 0);
    send_vec(16'b1101, 4);
    chk("t6_rst_pattern_1101", detected, 1);

    // Mixed stream with gaps, checked by the per-cycle compare only.
    load(4'b1011, 1'b1, 1'b0);
    for (int i = 31; i >= 0; i--)
      step(1'b0, 1'b0, mix_en[i], mix_bits[i], 1'b0, 4'b0000, 1'b0);
    load(4'b0101, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++)
      step(1'b0, 1'b0, mix_en[i], mix_bits[i], 1'b0, 4'b0000, 1'b0);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
